// File: rtl/read_module.sv
// Sequential gather of one scalar or a LANES-wide vector from a 1-cycle synchronous RAM.
// Define READ_STRIDE_EN to add the stride port; otherwise reads are unit-stride.
module read_module #(
    parameter int LANES = 20,
    parameter int DW    = 10,
    parameter int AW    = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       op_type,
    input  logic [AW-1:0]              base_address,
`ifdef READ_STRIDE_EN
    input  logic [AW-1:0]              stride,
`endif
    output logic                       read_en,
    output logic [AW-1:0]              read_address,
    input  logic [DW-1:0]              read_data,
    output logic [LANES-1:0][DW-1:0]   vector_data,
    output logic [DW-1:0]              scalar_data,
    output logic                       busy,
    output logic                       finished,
    output logic [1:0]                 state_dbg
);

    localparam int CW = $clog2(LANES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                     state_q, state_d;
    logic                       op_q, op_d;
    logic                       rd_en_q, rd_en_d;
    logic                       pend_q, pend_d;
    logic [AW-1:0]              addr_q, addr_d;
    logic [AW-1:0]              step_q, step_d;
    logic [CW-1:0]              iss_q, iss_d;
    logic [CW-1:0]              cap_q, cap_d;
    logic [LANES-1:0][DW-1:0]   vec_q, vec_d;
    logic [DW-1:0]              sc_q, sc_d;
    logic [CW-1:0]              last_idx;
    logic [AW-1:0]              step_in;

`ifdef READ_STRIDE_EN
    assign step_in = stride;
`else
    assign step_in = AW'(1);
`endif

    // start is a request pulse honoured only in IDLE or DONE; finished marks the
    // single cycle in which the result is complete. There is no back-pressure.
    assign last_idx = op_q ? CW'(LANES - 1) : '0;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_en_d = rd_en_q;
        pend_d  = rd_en_q;
        addr_d  = addr_q;
        step_d  = step_q;
        iss_d   = iss_q;
        cap_d   = cap_q;
        vec_d   = vec_q;
        sc_d    = sc_q;

        // read_data belongs to the read strobed in the previous cycle
        if (pend_q) begin
            if (op_q) begin
                for (int l = 0; l < LANES; l++) begin
                    if (cap_q == CW'(l)) vec_d[l] = read_data;
                end
            end else begin
                sc_d = read_data;
            end
            cap_d = cap_q + CW'(1);
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = ISSUE;
                    op_d    = op_type;
                    addr_d  = base_address;
                    step_d  = step_in;
                    rd_en_d = 1'b1;
                    iss_d   = '0;
                    cap_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (iss_q == last_idx) begin
                    rd_en_d = 1'b0;
                    state_d = DRAIN;
                end else begin
                    iss_d  = iss_q + CW'(1);
                    addr_d = addr_q + step_q;
                end
            end
            DRAIN:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            rd_en_q <= 1'b0;
            pend_q  <= 1'b0;
            addr_q  <= '0;
            step_q  <= '0;
            iss_q   <= '0;
            cap_q   <= '0;
            vec_q   <= '0;
            sc_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_en_q <= rd_en_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            step_q  <= step_d;
            iss_q   <= iss_d;
            cap_q   <= cap_d;
            vec_q   <= vec_d;
            sc_q    <= sc_d;
        end
    end

    assign read_en      = rd_en_q;
    assign read_address = addr_q;
    assign vector_data  = vec_q;
    assign scalar_data  = sc_q;
    assign busy         = (state_q == ISSUE) || (state_q == DRAIN);
    assign finished     = (state_q == DONE);
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_read_module.sv
// Randomized and directed bench for read_module: a driver issues loads, a monitor
// checks addresses, busy, latency and the gathered result against a queue of expectations.
module tb_read_module;
  localparam int LANES = 20;
  localparam int DW    = 10;
  localparam int AW    = 6;
  localparam int VW    = LANES * DW;
  localparam int MS    = 1 << AW;

  logic                     clk;
  logic                     rst;
  logic                     start;
  logic                     op_type;
  logic [AW-1:0]            base_address;
  logic [AW-1:0]            stride_r;
  logic                     read_en;
  logic [AW-1:0]            read_address;
  logic [DW-1:0]            read_data;
  logic [LANES-1:0][DW-1:0] vector_data;
  logic [DW-1:0]            scalar_data;
  logic                     busy;
  logic                     finished;
  logic [1:0]               state_dbg;

  read_module #(.LANES(LANES), .DW(DW), .AW(AW)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .op_type(op_type),
    .base_address(base_address),
`ifdef READ_STRIDE_EN
    .stride(stride_r),
`endif
    .read_en(read_en),
    .read_address(read_address),
    .read_data(read_data),
    .vector_data(vector_data),
    .scalar_data(scalar_data),
    .busy(busy),
    .finished(finished),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // synchronous RAM model: data appears the cycle after the strobe
  logic [DW-1:0] mem [MS];
  always @(posedge clk) if (read_en) read_data <= mem[read_address];

  // scoreboard state
  int total = 0;
  int bad   = 0;
  logic [AW-1:0] exp_addr_q[$];
  logic [VW-1:0] exp_vec_q[$];
  logic [DW-1:0] exp_sc_q[$];
  int            exp_fin_q[$];
  logic [VW-1:0] model_vec;
  logic [DW-1:0] model_sc;
  int            ws = -1;
  int            we = -1;
  logic          mon_en = 1'b0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // driver: called at a negedge while the DUT is idle or in its done cycle
  task automatic issue(input logic op, input logic [AW-1:0] base, input logic [AW-1:0] strd);
    int n;
    logic [AW-1:0] a;
`ifndef READ_STRIDE_EN
    strd = AW'(1);
`endif
    n = op ? LANES : 1;
    start = 1'b1;
    op_type = op;
    base_address = base;
    stride_r = strd;
    for (int k = 0; k < n; k++) begin
      a = AW'((int'(base) + k * int'(strd)) % MS);
      exp_addr_q.push_back(a);
      if (op) model_vec[k*DW +: DW] = mem[a];
      else model_sc = mem[a];
    end
    exp_vec_q.push_back(model_vec);
    exp_sc_q.push_back(model_sc);
    exp_fin_q.push_back(cyc + n + 2);
    ws = cyc + 1;
    we = cyc + n + 1;
    @(negedge clk);
    start = 1'b0;
    op_type = 1'($urandom);
    base_address = AW'($urandom);
    stride_r = AW'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (exp_fin_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_fin_q.size() != 0) flag("timeout_waiting_for_finished");
    @(negedge clk);
  endtask

  task automatic wait_finished();
    int t = 0;
    while (!finished && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!finished) flag("timeout_waiting_for_done_cycle");
  endtask

  task automatic apply_reset();
    #3;
    rst = 1'b0;
    #1;
    check("rst_read_en", 256'(read_en), 256'(0));
    check("rst_read_address", 256'(read_address), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_finished", 256'(finished), 256'(0));
    check("rst_vector_data", 256'(vector_data), 256'(0));
    check("rst_scalar_data", 256'(scalar_data), 256'(0));
    exp_addr_q.delete();
    exp_vec_q.delete();
    exp_sc_q.delete();
    exp_fin_q.delete();
    model_vec = '0;
    model_sc = '0;
    ws = -1;
    we = -1;
    repeat (2) @(negedge clk);
    #3;
    rst = 1'b1;
    @(negedge clk);
  endtask

  // monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (read_en) begin
        if (exp_addr_q.size() == 0) flag("unexpected_read");
        else check("read_address", 256'(read_address), 256'(exp_addr_q.pop_front()));
      end
      check("busy", 256'(busy), 256'((cyc >= ws) && (cyc <= we)));
      if (finished) begin
        if (exp_fin_q.size() == 0) begin
          flag("unexpected_finished");
        end else begin
          check("vector_data", 256'(vector_data), 256'(exp_vec_q.pop_front()));
          check("scalar_data", 256'(scalar_data), 256'(exp_sc_q.pop_front()));
          check("finish_cycle", 256'(cyc), 256'(exp_fin_q.pop_front()));
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    start = 1'b0;
    op_type = 1'b0;
    base_address = '0;
    stride_r = '0;
    model_vec = '0;
    model_sc = '0;
    for (int i = 0; i < MS; i++) mem[i] = DW'($urandom);

    @(negedge clk);
    check("init_read_en", 256'(read_en), 256'(0));
    check("init_busy", 256'(busy), 256'(0));
    check("init_finished", 256'(finished), 256'(0));
    check("init_vector_data", 256'(vector_data), 256'(0));
    check("init_scalar_data", 256'(scalar_data), 256'(0));
    #3;
    rst = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // vector load of a ramp, then a scalar load that must leave vector_data alone
    for (int i = 0; i < LANES; i++) mem[34 + i] = DW'(50 + i);
    issue(1'b1, AW'(34), AW'(1));
    wait_idle();
    mem[34] = DW'(160);
    issue(1'b0, AW'(34), AW'(1));
    wait_idle();

    // address wrap-around
    issue(1'b1, AW'(62), AW'(1));
    wait_idle();

    // start while busy is ignored; start in the done cycle is accepted
    issue(1'b1, AW'($urandom), AW'($urandom));
    repeat (4) @(negedge clk);
    start = 1'b1;
    op_type = 1'b0;
    base_address = AW'($urandom);
    @(negedge clk);
    start = 1'b0;
    wait_finished();
    issue(1'b0, AW'($urandom), AW'($urandom));
    wait_idle();

    // reset in cycle 8 of a vector load aborts it; a fresh load then completes
    issue(1'b1, AW'($urandom), AW'($urandom));
    repeat (7) @(negedge clk);
    apply_reset();
    repeat (30) @(negedge clk);
    issue(1'b1, AW'($urandom), AW'($urandom));
    wait_idle();

`ifdef READ_STRIDE_EN
    issue(1'b1, AW'(10), AW'(2));
    wait_idle();
    issue(1'b1, AW'(10), AW'(0));
    wait_idle();
`endif

    // randomized loads with fresh memory contents
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < MS; i++) mem[i] = DW'($urandom);
      issue(1'($urandom_range(0, 1)), AW'($urandom), AW'($urandom));
      wait_idle();
    end

    if (exp_addr_q.size() != 0) flag("reads_left_unissued");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
